// File: rtl/arc4_key_cracker.sv
// ARC4 key search: walks 24-bit candidate keys until the ROM ciphertext decrypts to printable
// ASCII, then shows the key on HEX5..HEX0 (or dashes if the range is exhausted).
module arc4_key_cracker #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter logic [23:0] KEY_END   = 24'hFFFFFF,
   // Ciphertext ROM init file name, packed 8 bits per character; used by the FPGA memory flow.
   parameter logic [47:0] CT_INIT   = "ct.mif"
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [9:0] LEDR
);

   typedef enum logic [3:0] {
      StInit, StKsaRi, StKsaRj, StKsaWi, StKsaWj,
      StPrRi, StPrRj, StPrWi, StPrWj, StPrRt, StPrOut,
      StNext, StFound, StFail
   } state_e;

   logic rst;
   assign rst = ~KEY[3];

   logic unused_inputs;
   assign unused_inputs = ^{SW, KEY[2:0], CT_INIT};

   state_e      state_q, state_d;
   logic [23:0] key_q, key_d;
   logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d;
   logic [7:0]  si_q, si_d, sj_q, sj_d, len_q, len_d;
   logic [1:0]  m_q, m_d;

   logic [7:0] s_mem  [256];
   logic [7:0] ct_rom [256];
   logic [7:0] pt_mem [256];
   logic [7:0] s_rdata, ct_rdata;
   logic       s_we, pt_we;
   logic [7:0] s_waddr, s_wdata, s_raddr, pt_waddr, pt_wdata, ct_raddr;

   logic [7:0] kb, i_inc, j_ksa, j_prga, p;
   logic       printable;

   always_comb begin
      unique case (m_q)
         2'd0:    kb = key_q[23:16];
         2'd1:    kb = key_q[15:8];
         default: kb = key_q[7:0];
      endcase
   end

   assign i_inc     = i_q + 8'd1;
   assign j_ksa     = j_q + s_rdata + kb;
   assign j_prga    = j_q + s_rdata;
   assign p         = s_rdata ^ ct_rdata;
   assign printable = (p >= 8'h20) && (p <= 8'h7E);

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         state_q <= StInit;
         key_q   <= KEY_START;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         len_q   <= '0;
         m_q     <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         len_q   <= len_d;
         m_q     <= m_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      si_d     = si_q;
      sj_d     = sj_q;
      len_d    = len_q;
      m_d      = m_q;
      s_we     = 1'b0;
      s_waddr  = i_q;
      s_wdata  = i_q;
      s_raddr  = i_q;
      pt_we    = 1'b0;
      pt_waddr = k_q;
      pt_wdata = p;
      // Hold CT[0] on the ROM port during init so the length is ready when init ends.
      ct_raddr = (state_q == StInit) ? 8'd0 : k_q;
      unique case (state_q)
         StInit: begin
            s_we = 1'b1;
            i_d  = i_inc;
            if (i_q == 8'hFF) begin
               len_d   = ct_rdata;
               j_d     = '0;
               m_d     = '0;
               state_d = StKsaRi;
            end
         end
         StKsaRi: begin
            pt_we    = (i_q == 8'd0);
            pt_waddr = 8'd0;
            pt_wdata = len_q;
            state_d  = StKsaRj;
         end
         StKsaRj: begin
            si_d    = s_rdata;
            j_d     = j_ksa;
            s_raddr = j_ksa;
            state_d = StKsaWi;
         end
         StKsaWi: begin
            s_we    = 1'b1;
            s_wdata = s_rdata;
            state_d = StKsaWj;
         end
         StKsaWj: begin
            s_we    = 1'b1;
            s_waddr = j_q;
            s_wdata = si_q;
            i_d     = i_inc;
            m_d     = (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
            if (i_q == 8'hFF) begin
               j_d     = '0;
               k_d     = 8'd1;
               state_d = StPrRi;
            end else begin
               state_d = StKsaRi;
            end
         end
         StPrRi: begin
            i_d     = i_inc;
            s_raddr = i_inc;
            state_d = StPrRj;
         end
         StPrRj: begin
            si_d    = s_rdata;
            j_d     = j_prga;
            s_raddr = j_prga;
            state_d = StPrWi;
         end
         StPrWi: begin
            s_we    = 1'b1;
            s_wdata = s_rdata;
            sj_d    = s_rdata;
            state_d = StPrWj;
         end
         StPrWj: begin
            s_we    = 1'b1;
            s_waddr = j_q;
            s_wdata = si_q;
            state_d = StPrRt;
         end
         // Keystream read waits until both swap writes have landed.
         StPrRt: begin
            s_raddr = si_q + sj_q;
            state_d = StPrOut;
         end
         StPrOut: begin
            pt_we = 1'b1;
            if (!printable) begin
               state_d = StNext;
            end else if (k_q == len_q) begin
               state_d = StFound;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = StPrRi;
            end
         end
         StNext: begin
            if (key_q == KEY_END) begin
               state_d = StFail;
            end else begin
               key_d   = key_q + 24'd1;
               i_d     = '0;
               state_d = StInit;
            end
         end
         StFound: state_d = StFound;
         StFail:  state_d = StFail;
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (s_we) s_mem[s_waddr] <= s_wdata;
      s_rdata <= s_mem[s_raddr];
      if (pt_we) pt_mem[pt_waddr] <= pt_wdata;
      ct_rdata <= ct_rom[ct_raddr];
   end

   function automatic logic [6:0] seg(input logic [3:0] n);
      unique case (n)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   endfunction

   always_comb begin
      HEX0 = 7'h7F;
      HEX1 = 7'h7F;
      HEX2 = 7'h7F;
      HEX3 = 7'h7F;
      HEX4 = 7'h7F;
      HEX5 = 7'h7F;
      LEDR = '0;
      if (state_q == StFound) begin
         HEX0      = seg(key_q[3:0]);
         HEX1      = seg(key_q[7:4]);
         HEX2      = seg(key_q[11:8]);
         HEX3      = seg(key_q[15:12]);
         HEX4      = seg(key_q[19:16]);
         HEX5      = seg(key_q[23:20]);
         LEDR[1:0] = 2'b11;
      end else if (state_q == StFail) begin
         HEX0      = 7'h3F;
         HEX1      = 7'h3F;
         HEX2      = 7'h3F;
         HEX3      = 7'h3F;
         HEX4      = 7'h3F;
         HEX5      = 7'h3F;
         LEDR[1:0] = 2'b01;
      end
   end

endmodule

// File: tb/tb_arc4_key_cracker.sv
// Runs four crackers side by side (found, exhausted range, low-byte rollover, mid-KSA reset)
// against an ARC4 reference model; expected display states flow through a scoreboard queue.
module tb_arc4_key_cracker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  keys  [4];
   logic [9:0]  sws   [4];
   logic [41:0] hexv  [4];
   logic [9:0]  ledr  [4];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic [41:0] hex;
      logic [9:0]  led;
   } exp_t;
   exp_t sb [$];

   logic [7:0] ms   [256];
   logic [7:0] mks  [256];
   logic [7:0] ct_a [256];
   logic [7:0] ct_b [256];
   logic [7:0] ct_c [256];
   logic [7:0] plain [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   arc4_key_cracker #(.KEY_START(24'h000000), .KEY_END(24'hFFFFFF)) dut_a (
      .CLOCK_50(clk), .KEY(keys[0]), .SW(sws[0]),
      .HEX0(hexv[0][6:0]), .HEX1(hexv[0][13:7]), .HEX2(hexv[0][20:14]),
      .HEX3(hexv[0][27:21]), .HEX4(hexv[0][34:28]), .HEX5(hexv[0][41:35]), .LEDR(ledr[0]));
   arc4_key_cracker #(.KEY_START(24'h000001), .KEY_END(24'h000001)) dut_b (
      .CLOCK_50(clk), .KEY(keys[1]), .SW(sws[1]),
      .HEX0(hexv[1][6:0]), .HEX1(hexv[1][13:7]), .HEX2(hexv[1][20:14]),
      .HEX3(hexv[1][27:21]), .HEX4(hexv[1][34:28]), .HEX5(hexv[1][41:35]), .LEDR(ledr[1]));
   arc4_key_cracker #(.KEY_START(24'h0000F8), .KEY_END(24'hFFFFFF)) dut_c (
      .CLOCK_50(clk), .KEY(keys[2]), .SW(sws[2]),
      .HEX0(hexv[2][6:0]), .HEX1(hexv[2][13:7]), .HEX2(hexv[2][20:14]),
      .HEX3(hexv[2][27:21]), .HEX4(hexv[2][34:28]), .HEX5(hexv[2][41:35]), .LEDR(ledr[2]));
   arc4_key_cracker #(.KEY_START(24'h000000), .KEY_END(24'hFFFFFF)) dut_d (
      .CLOCK_50(clk), .KEY(keys[3]), .SW(sws[3]),
      .HEX0(hexv[3][6:0]), .HEX1(hexv[3][13:7]), .HEX2(hexv[3][20:14]),
      .HEX3(hexv[3][27:21]), .HEX4(hexv[3][34:28]), .HEX5(hexv[3][41:35]), .LEDR(ledr[3]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference ARC4: leaves the final permutation in ms and keystream bytes 1..n in mks.
   task automatic model_arc4(input logic [23:0] key, input int n);
      logic [7:0] kb [3];
      logic [7:0] i, j, t;
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int x = 0; x < 256; x++) ms[x] = x[7:0];
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         i     = x[7:0];
         j     = j + ms[i] + kb[x % 3];
         t     = ms[i];
         ms[i] = ms[j];
         ms[j] = t;
      end
      i = 8'd0;
      j = 8'd0;
      for (int k = 1; k <= n; k++) begin
         i      = i + 8'd1;
         j      = j + ms[i];
         t      = ms[i];
         ms[i]  = ms[j];
         ms[j]  = t;
         t      = ms[i] + ms[j];
         mks[k] = ms[t];
      end
   endtask

   task automatic model_search(input logic [23:0] ks, input logic [23:0] ke,
                               input logic [7:0] ct [256],
                               output logic found, output logic [23:0] fk);
      logic [23:0] key;
      logic        ok;
      logic [7:0]  p;
      key   = ks;
      found = 1'b0;
      fk    = ks;
      for (int g = 0; g < 2 ** 24; g++) begin
         model_arc4(key, int'(ct[0]));
         ok = 1'b1;
         for (int k = 1; k <= int'(ct[0]); k++) begin
            p = ct[k] ^ mks[k];
            if (p < 8'h20 || p > 8'h7E) begin
               ok = 1'b0;
               break;
            end
         end
         if (ok) begin
            found = 1'b1;
            fk    = key;
            break;
         end
         if (key == ke) break;
         key = key + 24'd1;
      end
   endtask

   task automatic expect_result(input string tag, input logic [23:0] ks, input logic [23:0] ke,
                                input logic [7:0] ct [256], output logic [23:0] fk);
      exp_t e;
      logic found;
      model_search(ks, ke, ct, found, fk);
      e.tag = tag;
      if (found) begin
         e.hex = {glyph_tab[fk[23:20]], glyph_tab[fk[19:16]], glyph_tab[fk[15:12]],
                  glyph_tab[fk[11:8]], glyph_tab[fk[7:4]], glyph_tab[fk[3:0]]};
         e.led = 10'b11;
      end else begin
         e.hex = {6{7'h3F}};
         e.led = 10'b01;
      end
      sb.push_back(e);
   endtask

   initial begin
      exp_t        e;
      int          done_cyc [4];
      logic        all_done;
      logic [23:0] fk_a, fk_b, fk_c, fk_d;

      for (int d = 0; d < 4; d++) begin
         keys[d]     = 4'h7;
         sws[d]      = '0;
         done_cyc[d] = -1;
      end
      for (int n = 0; n < 256; n++) begin
         ct_a[n] = 8'h00;
         ct_b[n] = 8'h00;
         ct_c[n] = 8'h00;
      end
      model_arc4(24'h000018, 5);
      ct_a[0] = 8'd5;
      for (int k = 1; k <= 5; k++) ct_a[k] = plain[k-1] ^ mks[k];
      model_arc4(24'h0000FF, 5);
      ct_c[0] = 8'd5;
      for (int k = 1; k <= 5; k++) ct_c[k] = plain[k-1] ^ mks[k];
      // Key 1 decrypts byte 1 to 8'h00, so it is rejected at the first byte.
      model_arc4(24'h000001, 5);
      ct_b[0] = 8'd5;
      ct_b[1] = mks[1];
      for (int k = 2; k <= 5; k++) ct_b[k] = ct_a[k];
      for (int n = 0; n < 256; n++) begin
         dut_a.ct_rom[n] = ct_a[n];
         dut_b.ct_rom[n] = ct_b[n];
         dut_c.ct_rom[n] = ct_c[n];
         dut_d.ct_rom[n] = ct_a[n];
      end

      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0 || c == 9) begin
            for (int d = 0; d < 4; d++) begin
               check($sformatf("rst%0d_hex_d%0d", c, d), 64'(hexv[d]), 64'({6{7'h7F}}));
               check($sformatf("rst%0d_ledr_d%0d", c, d), 64'(ledr[d]), 64'd0);
            end
         end
      end

      expect_result("a", 24'h000000, 24'hFFFFFF, ct_a, fk_a);
      expect_result("b", 24'h000001, 24'h000001, ct_b, fk_b);
      expect_result("c", 24'h0000F8, 24'hFFFFFF, ct_c, fk_c);
      expect_result("d", 24'h000000, 24'hFFFFFF, ct_a, fk_d);

      for (int d = 0; d < 4; d++) keys[d] = 4'hF;
      for (int c = 1; c <= 60000; c++) begin
         @(negedge clk);
         // Cycle 600 falls inside the first key's KSA.
         if (c == 600) keys[3] = 4'h7;
         if (c == 610) begin
            check("d_midrst_hex", 64'(hexv[3]), 64'({6{7'h7F}}));
            check("d_midrst_ledr", 64'(ledr[3]), 64'd0);
            keys[3] = 4'hF;
         end
         all_done = 1'b1;
         for (int d = 0; d < 4; d++) begin
            if (ledr[d][0] && done_cyc[d] < 0) done_cyc[d] = c;
            if (!ledr[d][0]) all_done = 1'b0;
         end
         if (all_done && c > 610) break;
      end
      repeat (20) @(negedge clk);

      for (int d = 0; d < 4; d++) begin
         e = sb.pop_front();
         check({e.tag, "_done"}, 64'(done_cyc[d] > 0), 64'd1);
         check({e.tag, "_hex"}, 64'(hexv[d]), 64'(e.hex));
         check({e.tag, "_ledr"}, 64'(ledr[d]), 64'(e.led));
      end
      check("b_reject_cycles", 64'(done_cyc[1] > 0 && done_cyc[1] <= 1600), 64'd1);

      model_arc4(fk_a, 5);
      check("a_pt0", 64'(dut_a.pt_mem[0]), 64'd5);
      check("d_pt0", 64'(dut_d.pt_mem[0]), 64'd5);
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("a_pt%0d", k), 64'(dut_a.pt_mem[k]), 64'(ct_a[k] ^ mks[k]));
         check($sformatf("d_pt%0d", k), 64'(dut_d.pt_mem[k]), 64'(ct_a[k] ^ mks[k]));
      end
      for (int x = 0; x < 256; x++) begin
         check($sformatf("a_s%0d", x), 64'(dut_a.s_mem[x]), 64'(ms[x]));
         check($sformatf("d_s%0d", x), 64'(dut_d.s_mem[x]), 64'(ms[x]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
